// File: rtl/scheduler_multi_issue.sv
// scheduler_multi_issue: multi-issue arbiter over policy engine proposals with in-order retirement
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   mode                  : requested policy index, applied once in-flight grants drain
//   policy_selection/valid: queue proposal and valid flag from each policy engine
//   empty                 : per-queue empty flags
//   consumed              : completion level, each rising edge retires the oldest grant
//   grant, grant_id       : one-cycle issue pulse and the granted queue
//   hasBeenConsumed       : one-hot retirement strobe, same cycle as the consumed edge
//   active_mode, outstanding, draining, protocol_error : status
module scheduler_multi_issue #(
   parameter int NUMBER_OF_QUEUES = 4,
   parameter int NUMBER_OF_POLICIES = 7,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVATION_LIMIT = 1024,
   parameter int COUNTER_SIZE = 16,
   localparam int QW = $clog2(NUMBER_OF_QUEUES),
   localparam int PW = NUMBER_OF_POLICIES > 1 ? $clog2(NUMBER_OF_POLICIES) : 1,
   localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [PW-1:0]                        mode,
   input  logic [NUMBER_OF_POLICIES-1:0][QW-1:0] policy_selection,
   input  logic [NUMBER_OF_POLICIES-1:0]         policy_valid,
   input  logic [NUMBER_OF_QUEUES-1:0]           empty,
   input  logic                                 consumed,
   output logic                                 grant,
   output logic [QW-1:0]                        grant_id,
   output logic [NUMBER_OF_QUEUES-1:0]           hasBeenConsumed,
   output logic [PW-1:0]                        active_mode,
   output logic [OW-1:0]                        outstanding,
   output logic                                 draining,
   output logic                                 protocol_error
);
   localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   typedef enum logic {RUN, DRAIN} state_t;
   state_t state;
   logic consumed_ff;
   logic [NUMBER_OF_QUEUES-1:0] in_flight;
   logic [QW-1:0] order [MAX_OUTSTANDING];
   logic [AW-1:0] head, tail;
   logic [COUNTER_SIZE-1:0] wait_count [NUMBER_OF_QUEUES];
   logic [NUMBER_OF_QUEUES-1:0] starved;
   logic completion, retire, issue, cand_valid;
   logic [QW-1:0] cand;
   logic [OW-1:0] outstanding_next;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(MAX_OUTSTANDING - 1) ? '0 : p + AW'(1);
   endfunction

   assign completion = consumed & ~consumed_ff;
   assign retire = completion && outstanding != '0;
   assign draining = state == DRAIN;
   assign hasBeenConsumed = retire ? NUMBER_OF_QUEUES'(1) << order[head] : '0;
   assign issue = state == RUN && outstanding < OW'(MAX_OUTSTANDING) && cand_valid && !empty[cand] && !in_flight[cand];
   assign outstanding_next = outstanding + OW'(issue) - OW'(retire);

   // Any starved queue suppresses the policy entirely; only a starved queue not already in flight may win.
   always_comb begin
      starved = '0;
      cand = '0;
      cand_valid = 1'b0;
      for (int q = 0; q < NUMBER_OF_QUEUES; q++)
         starved[q] = STARVATION_LIMIT != 0 && wait_count[q] == COUNTER_SIZE'(STARVATION_LIMIT);
      if (|starved) begin
         for (int q = NUMBER_OF_QUEUES - 1; q >= 0; q--)
            if (starved[q] && !in_flight[q]) begin
               cand = QW'(q);
               cand_valid = 1'b1;
            end
      end else begin
         for (int p = 0; p < NUMBER_OF_POLICIES; p++)
            if (active_mode == PW'(p)) begin
               cand = policy_selection[p];
               cand_valid = policy_valid[p];
            end
      end
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state <= RUN;
         active_mode <= '0;
         grant <= 1'b0;
         grant_id <= '0;
         outstanding <= '0;
         protocol_error <= 1'b0;
         consumed_ff <= 1'b1;
         in_flight <= '0;
         head <= '0;
         tail <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) order[i] <= '0;
         for (int q = 0; q < NUMBER_OF_QUEUES; q++) wait_count[q] <= '0;
      end else begin
         consumed_ff <= consumed;
         grant <= issue;
         outstanding <= outstanding_next;
         if (completion && !retire) protocol_error <= 1'b1;
         if (issue) begin
            grant_id <= cand;
            order[tail] <= cand;
            tail <= nxt(tail);
         end
         if (retire) head <= nxt(head);
         in_flight <= (in_flight | (issue ? NUMBER_OF_QUEUES'(1) << cand : '0)) & ~hasBeenConsumed;
         for (int q = 0; q < NUMBER_OF_QUEUES; q++)
            wait_count[q] <= empty[q] || (issue && cand == QW'(q)) ? '0 :
                             wait_count[q] < COUNTER_SIZE'(STARVATION_LIMIT) ? wait_count[q] + 1'b1 : wait_count[q];
         // The mode reload waits for the post-edge outstanding count so the last retirement and the switch share an edge.
         if (state == RUN)
            state <= mode != active_mode ? DRAIN : RUN;
         else if (outstanding_next == '0) begin
            active_mode <= mode;
            state <= RUN;
         end else if (mode == active_mode)
            state <= RUN;
      end
endmodule

// File: tb/tb_scheduler_multi_issue.sv
// tb_scheduler_multi_issue: directed and random stimulus against a queue-based reference model
module tb_scheduler_multi_issue;
   localparam int NQ = 4, NP = 7, MAX = 2, LIM = 8;
   logic clock = 1'b0, reset = 1'b0;
   logic [2:0] mode = '0;
   logic [NP-1:0][1:0] policy_selection = '0;
   logic [NP-1:0] policy_valid = '0;
   logic [NQ-1:0] empty = '1;
   logic consumed = 1'b1;
   logic grant, draining, protocol_error;
   logic [1:0] grant_id, outstanding;
   logic [NQ-1:0] hasBeenConsumed;
   logic [2:0] active_mode;
   int checks = 0, failures = 0;
   int m_act, m_gid, m_cnt[NQ], m_q[$];
   bit m_grant, m_drain, m_err, m_cff, m_fl[NQ];

   always #5 clock = ~clock;

   scheduler_multi_issue #(
      .NUMBER_OF_QUEUES(NQ), .NUMBER_OF_POLICIES(NP), .MAX_OUTSTANDING(MAX),
      .STARVATION_LIMIT(LIM), .COUNTER_SIZE(16)
   ) dut (
      .clock(clock), .reset(reset), .mode(mode), .policy_selection(policy_selection),
      .policy_valid(policy_valid), .empty(empty), .consumed(consumed), .grant(grant),
      .grant_id(grant_id), .hasBeenConsumed(hasBeenConsumed), .active_mode(active_mode),
      .outstanding(outstanding), .draining(draining), .protocol_error(protocol_error)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_gid = 0; m_grant = 0; m_drain = 0; m_err = 0; m_cff = 1;
      m_q.delete();
      for (int q = 0; q < NQ; q++) begin m_fl[q] = 0; m_cnt[q] = 0; end
   endtask

   task automatic check_regs();
      check("grant", 32'(grant), 32'(m_grant));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("active_mode", 32'(active_mode), 32'(m_act));
      check("outstanding", 32'(outstanding), 32'(m_q.size()));
      check("draining", 32'(draining), 32'(m_drain));
      check("protocol_error", 32'(protocol_error), 32'(m_err));
   endtask

   // Called right after a negedge with inputs applied; predicts one clock edge.
   task automatic step();
      bit comp, iss, any_st;
      int c;
      logic [NQ-1:0] hbc;
      #1;
      comp = consumed && !m_cff;
      hbc = '0;
      if (comp && m_q.size() > 0) hbc[m_q[0]] = 1'b1;
      check("hasBeenConsumed", 32'(hasBeenConsumed), 32'(hbc));
      c = -1;
      any_st = 0;
      for (int q = 0; q < NQ; q++) if (m_cnt[q] == LIM) any_st = 1;
      if (any_st) begin
         for (int q = NQ - 1; q >= 0; q--) if (m_cnt[q] == LIM && !m_fl[q]) c = q;
      end else if (m_act < NP && policy_valid[m_act]) c = int'(policy_selection[m_act]);
      iss = !m_drain && m_q.size() < MAX && c >= 0 && !empty[c] && !m_fl[c];
      m_grant = iss;
      if (iss) m_gid = c;
      for (int q = 0; q < NQ; q++)
         m_cnt[q] = (empty[q] || (iss && c == q)) ? 0 : (m_cnt[q] < LIM ? m_cnt[q] + 1 : LIM);
      if (comp && m_q.size() == 0) m_err = 1;
      if (comp && m_q.size() > 0) begin m_fl[m_q[0]] = 0; void'(m_q.pop_front()); end
      if (iss) begin m_q.push_back(c); m_fl[c] = 1; end
      if (!m_drain) m_drain = int'(mode) != m_act;
      else if (m_q.size() == 0) begin m_act = int'(mode); m_drain = 0; end
      else if (int'(mode) == m_act) m_drain = 0;
      m_cff = consumed;
      @(posedge clock);
      #1;
      check_regs();
      @(negedge clock);
   endtask

   task automatic wait_grant(input string tag, input int budget, input int exp_id);
      int n = 0;
      do begin step(); n++; end while (!grant && n < budget);
      check({tag, "_seen"}, 32'(grant), 1);
      check(tag, 32'(grant_id), 32'(exp_id));
   endtask

   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 0);
      check("rst_grant_id", 32'(grant_id), 0);
      check("rst_active_mode", 32'(active_mode), 0);
      check("rst_outstanding", 32'(outstanding), 0);
      check("rst_draining", 32'(draining), 0);
      check("rst_protocol_error", 32'(protocol_error), 0);
      check("rst_strobe", 32'(hasBeenConsumed), 0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic idle(input int n);
      empty = '1;
      policy_valid = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      model_reset();
      #1;
      check_regs();
      check("rst_strobe", 32'(hasBeenConsumed), 0);
      @(negedge clock);
      reset = 1'b1;
      // single grant, held until its completion
      mode = 3'd1; policy_selection[1] = 2'd2; policy_valid[1] = 1'b1; empty = '0;
      wait_grant("s1_grant", 6, 2);
      step(); step();
      check("s1_outstanding", 32'(outstanding), 1);
      consumed = 1'b0; step();
      consumed = 1'b1; #1 check("s1_strobe", 32'(hasBeenConsumed), 4); step();
      check("s1_retired", 32'(outstanding), 0);
      idle(1);
      // two grants fill the window, third blocked, in-order retirement
      consumed = 1'b0; empty = 4'b0100; policy_valid[1] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         policy_selection[1] = i % 3 == 0 ? 2'd0 : i % 3 == 1 ? 2'd1 : 2'd3;
         step();
         if (i < 2) check("s2_grant_id", 32'(grant_id), 32'(i));
      end
      check("s2_outstanding", 32'(outstanding), 2);
      empty = '1; policy_valid = '0;
      consumed = 1'b1; #1 check("s2_strobe0", 32'(hasBeenConsumed), 1); step();
      consumed = 1'b0; step();
      consumed = 1'b1; #1 check("s2_strobe1", 32'(hasBeenConsumed), 2); step();
      check("s2_empty", 32'(outstanding), 0);
      // mode switch deferred behind two in-flight grants
      consumed = 1'b0; empty = 4'b1100; policy_valid[1] = 1'b1; policy_selection[1] = 2'd0; step();
      policy_selection[1] = 2'd1; step();
      empty = '1; mode = 3'd3; policy_selection[3] = 2'd2; policy_valid[3] = 1'b1; step();
      check("s3_draining", 32'(draining), 1);
      step(); step();
      check("s3_mode_held", 32'(active_mode), 1);
      consumed = 1'b1; step();
      check("s3_mode_held2", 32'(active_mode), 1);
      consumed = 1'b0; step();
      consumed = 1'b1; step();
      check("s3_mode_switched", 32'(active_mode), 3);
      check("s3_drain_done", 32'(draining), 0);
      empty = 4'b1011;
      wait_grant("s3_grant", 4, 2);
      // starvation override
      empty = '1; policy_valid = '0;
      consumed = 1'b0; step();
      consumed = 1'b1; step();
      policy_selection[3] = 2'd0; policy_valid[3] = 1'b1; empty = 4'b0110;
      wait_grant("s4_first", 4, 0);
      wait_grant("s4_starved", 20, 3);
      // protocol error, then asynchronous reset mid-transaction
      empty = '1; policy_valid = '0;
      consumed = 1'b0; step();
      consumed = 1'b1; step();
      consumed = 1'b0; step();
      consumed = 1'b1; step();
      check("s5_drained", 32'(outstanding), 0);
      consumed = 1'b0; step();
      consumed = 1'b1; #1 check("s5_no_strobe", 32'(hasBeenConsumed), 0); step();
      check("s5_error", 32'(protocol_error), 1);
      consumed = 1'b0; step(); step();
      check("s5_error_sticky", 32'(protocol_error), 1);
      policy_selection[3] = 2'd1; policy_valid[3] = 1'b1; empty = 4'b1101;
      wait_grant("s5_pre", 4, 1);
      consumed = 1'b1;
      async_reset();
      step();
      // issue and completion in the same cycle
      consumed = 1'b0;
      wait_grant("s6_first", 6, 1);
      policy_selection[3] = 2'd2; empty = 4'b1011; consumed = 1'b1;
      #1 check("s6_strobe", 32'(hasBeenConsumed), 2);
      step();
      check("s6_outstanding", 32'(outstanding), 1);
      check("s6_grant", 32'(grant), 1);
      check("s6_grant_id", 32'(grant_id), 2);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) mode = 3'($urandom_range(0, 7));
         for (int p = 0; p < NP; p++) policy_selection[p] = 2'($urandom);
         policy_valid = 7'($urandom);
         for (int q = 0; q < NQ; q++) empty[q] = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 2) == 0) consumed = ~consumed;
         if ($urandom_range(0, 499) == 0) async_reset();
         else step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
